// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures period and active time of a PWM pin in clk
// cycles and converts them to a DUTY_BITS-wide intensity code
// (round-half-up, computed by a 1-bit-per-cycle restoring divider).
// Optional build macro: PWM_CAP_GLITCH_EN enables a GLITCH_CYCLES stability
// filter on the synchronised input. Without it, act is the synced level.
module pwm_duty_capture #(
  parameter int CNT_W         = 16,
  parameter int DUTY_BITS     = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  output logic [DUTY_BITS-1:0] duty,
  output logic [CNT_W-1:0]     period,
  output logic [CNT_W-1:0]     on_time,
  output logic                 valid,
  output logic                 stuck,
  output logic                 overrun
);

  localparam int NUM_W  = CNT_W + DUTY_BITS;
  localparam int DCNT_W = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;
  localparam logic [DUTY_BITS-1:0] MAXD    = '1;
  // act level implied by the synchroniser's reset value of 0
  localparam logic ACT_RST = (ACTIVE_LOW != 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ON    = 2'd1;
  localparam logic [1:0] S_OFF   = 2'd2;
  localparam logic [1:0] S_STUCK = 2'd3;

  if (GLITCH_CYCLES < 1) begin : g_bad_glitch
    $error("GLITCH_CYCLES must be at least 1");
  end

  logic sync1_q, sync2_q, act_raw, act, act_q, rise, fall;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, on_cnt_q, on_cnt_d, on_lat_q, on_lat_d;
  logic [CNT_W-1:0] per_inc, on_inc;
  logic close, enter_stuck, stuck_clr;

  logic                 busy_q, div_done, ge;
  logic [DCNT_W-1:0]    dcnt_q;
  logic [CNT_W-1:0]     rem_q, rem_nx, den_q, mon_q;
  logic [CNT_W:0]       rem_sh;
  logic [NUM_W-1:0]     quo_q, quo_nx, num;
  logic [DUTY_BITS-1:0] duty_res;

  logic [DUTY_BITS-1:0] duty_q;
  logic [CNT_W-1:0]     period_q, on_time_q;
  logic                 valid_q, stuck_q, overrun_q;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

  assign act_raw = sync2_q ^ ACT_RST;

`ifdef PWM_CAP_GLITCH_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  logic [GW-1:0] gcnt_q;
  logic          flt_q;

  // Accept a new level only after it has held GLITCH_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q  <= ACT_RST;
      gcnt_q <= '0;
    end else if (act_raw == flt_q) begin
      gcnt_q <= '0;
    end else if (gcnt_q == GW'(GLITCH_CYCLES - 1)) begin
      flt_q  <= act_raw;
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_q + GW'(1);
    end
  end

  assign act = flt_q;
`else
  assign act = act_raw;
`endif

  // Previous act level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) act_q <= ACT_RST;
    else        act_q <= act;
  end

  assign rise    = act & ~act_q;
  assign fall    = ~act & act_q;
  assign per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);
  assign on_inc  = (on_cnt_q == CNT_MAX) ? on_cnt_q : on_cnt_q + CNT_W'(1);

  // Measurement FSM; edges are tested before timeouts so an edge wins.
  // In IDLE per_cnt doubles as the no-edge timer.
  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    on_cnt_d    = on_cnt_q;
    on_lat_d    = on_lat_q;
    close       = 1'b0;
    enter_stuck = 1'b0;
    stuck_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d   = S_ON;
          per_cnt_d = CNT_W'(1);
          on_cnt_d  = CNT_W'(1);
        end else if (fall) begin
          per_cnt_d = '0;
        end else begin
          per_cnt_d = per_inc;
          if (per_cnt_q == CNT_MAX) begin
            state_d     = S_STUCK;
            enter_stuck = 1'b1;
          end
        end
      end
      S_ON: begin
        if (fall) begin
          on_lat_d  = on_cnt_q;
          per_cnt_d = per_inc;
          state_d   = S_OFF;
        end else if (per_cnt_q == CNT_MAX) begin
          state_d     = S_STUCK;
          enter_stuck = 1'b1;
        end else begin
          per_cnt_d = per_inc;
          on_cnt_d  = on_inc;
        end
      end
      S_OFF: begin
        if (rise) begin
          close     = 1'b1;
          per_cnt_d = CNT_W'(1);
          on_cnt_d  = CNT_W'(1);
          state_d   = S_ON;
        end else if (per_cnt_q == CNT_MAX) begin
          state_d     = S_STUCK;
          enter_stuck = 1'b1;
        end else begin
          per_cnt_d = per_inc;
        end
      end
      default: begin
        if (rise) begin
          state_d   = S_ON;
          per_cnt_d = CNT_W'(1);
          on_cnt_d  = CNT_W'(1);
          stuck_clr = 1'b1;
        end else if (fall) begin
          state_d   = S_IDLE;
          per_cnt_d = '0;
          stuck_clr = 1'b1;
        end
      end
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      per_cnt_q <= '0;
      on_cnt_q  <= '0;
      on_lat_q  <= '0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      on_cnt_q  <= on_cnt_d;
      on_lat_q  <= on_lat_d;
    end
  end

  // Rounding term period/2 folded into the numerator up front
  assign num = NUM_W'(on_lat_q) * NUM_W'(MAXD) + NUM_W'(per_cnt_q >> 1);

  // One restoring-division step per cycle
  always_comb begin
    rem_sh   = {rem_q, quo_q[NUM_W-1]};
    ge       = (rem_sh >= {1'b0, den_q});
    rem_nx   = ge ? CNT_W'(rem_sh - {1'b0, den_q}) : rem_sh[CNT_W-1:0];
    quo_nx   = {quo_q[NUM_W-2:0], ge};
    duty_res = (quo_nx > NUM_W'(MAXD)) ? MAXD : quo_nx[DUTY_BITS-1:0];
  end

  assign div_done = busy_q && (dcnt_q == DCNT_W'(1));

  // Divider: loads on a closing edge when idle, runs NUM_W steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      dcnt_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      mon_q  <= '0;
    end else if (close && !busy_q) begin
      busy_q <= 1'b1;
      dcnt_q <= DCNT_W'(NUM_W);
      rem_q  <= '0;
      quo_q  <= num;
      den_q  <= per_cnt_q;
      mon_q  <= on_lat_q;
    end else if (busy_q) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      dcnt_q <= dcnt_q - DCNT_W'(1);
      if (div_done) busy_q <= 1'b0;
    end
  end

  // Output registers: timeout report, division result, sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= '0;
      period_q  <= '0;
      on_time_q <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (close && busy_q) overrun_q <= 1'b1;
      if (enter_stuck) begin
        period_q  <= '0;
        on_time_q <= '0;
        duty_q    <= act ? MAXD : '0;
        stuck_q   <= 1'b1;
        valid_q   <= 1'b1;
      end else if (div_done) begin
        duty_q    <= duty_res;
        period_q  <= den_q;
        on_time_q <= mon_q;
        valid_q   <= 1'b1;
      end
      if (stuck_clr) stuck_q <= 1'b0;
    end
  end

  assign duty    = duty_q;
  assign period  = period_q;
  assign on_time = on_time_q;
  assign valid   = valid_q;
  assign stuck   = stuck_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Testbench for pwm_duty_capture. Expected measurements are pushed when the
// closing edge is driven and compared against valid pulses captured by a
// monitor. CNT_W is reduced to 12 so timeouts fit a short run.
module tb_pwm_duty_capture;

  localparam int CNT_W         = 12;
  localparam int DUTY_BITS     = 4;
  localparam int GLITCH_CYCLES = 4;
  localparam int MAXD          = 15;
  localparam int CNT_MAX       = 4095;
  localparam int LAT           = CNT_W + DUTY_BITS + 1;
`ifdef PWM_CAP_GLITCH_EN
  localparam int FLT_DLY = GLITCH_CYCLES;
`else
  localparam int FLT_DLY = 0;
`endif
  localparam int DET = 2 + FLT_DLY;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 pwm_in = 1'b1;
  logic [DUTY_BITS-1:0] duty;
  logic [CNT_W-1:0]     period, on_time;
  logic                 valid, stuck, overrun;

  typedef struct {
    int cyc;
    int per;
    int on;
    int duty;
  } meas_t;

  meas_t exp_q[$];
  meas_t obs_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  bit    exp_ovr;
  int    last_start;

  pwm_duty_capture #(
    .CNT_W(CNT_W),
    .DUTY_BITS(DUTY_BITS),
    .ACTIVE_LOW(1),
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .duty(duty),
    .period(period),
    .on_time(on_time),
    .valid(valid),
    .stuck(stuck),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) obs_q.push_back('{cyc, int'(period), int'(on_time), int'(duty)});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_duty(input int on, input int per);
    int d;
    d = (on * MAXD + per / 2) / per;
    return (d > MAXD) ? MAXD : d;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    pwm_in = 1'b1;
    rst_n  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    exp_q.delete();
    obs_q.delete();
    exp_ovr    = 1'b0;
    last_start = -1000000;
  endtask

  // Drives n full periods (active = pin low); each closing edge is either
  // scheduled as a measurement or predicted as an overrun.
  task automatic run_pwm(input int on, input int off, input int n, input int spike);
    int d;
    pwm_in = 1'b1;
    tick(4);
    for (int i = 0; i <= n; i++) begin
      pwm_in = 1'b0;
      if (i > 0) begin
        d = cyc + DET;
        if (d - last_start >= LAT) begin
          exp_q.push_back('{d + LAT, on + off, on, exp_duty(on, on + off)});
          last_start = d;
        end else begin
          exp_ovr = 1'b1;
        end
      end
      if (i == n) break;
      if (spike > 0) begin
        tick(spike);
        pwm_in = 1'b1;
        tick(2);
        pwm_in = 1'b0;
        tick(on - spike - 2);
      end else begin
        tick(on);
      end
      pwm_in = 1'b1;
      tick(off);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (duty !== '0) $display("FAIL reset_duty: got %0d expected 0", duty); else n_pass++;
    n_checks++; if (period !== '0) $display("FAIL reset_period: got %0d expected 0", period); else n_pass++;
    n_checks++; if (on_time !== '0) $display("FAIL reset_on_time: got %0d expected 0", on_time); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
    n_checks++; if (stuck !== 1'b0) $display("FAIL reset_stuck: got %b expected 0", stuck); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
  endtask

  task automatic test_duty_patterns();
    int    tab_on[3]  = '{512, 64, 960};
    int    tab_off[3] = '{512, 960, 64};
    int    tab_n[3]   = '{3, 2, 2};
    meas_t e, o;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      run_pwm(tab_on[r], tab_off[r], tab_n[r], 0);
      for (int k = 0; k < LAT + 60 && obs_q.size() < exp_q.size(); k++) tick(1);
      tick(4);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin
          $display("FAIL duty%0d_valid: no valid pulse, expected at cycle %0d", r, e.cyc);
        end else begin
          n_pass++;
          o = obs_q.pop_front();
          n_checks++; if (o.cyc !== e.cyc) $display("FAIL duty%0d_latency: valid at cycle %0d expected %0d", r, o.cyc, e.cyc); else n_pass++;
          n_checks++; if (o.per !== e.per) $display("FAIL duty%0d_period: got %0d expected %0d", r, o.per, e.per); else n_pass++;
          n_checks++; if (o.on !== e.on) $display("FAIL duty%0d_on_time: got %0d expected %0d", r, o.on, e.on); else n_pass++;
          n_checks++; if (o.duty !== e.duty) $display("FAIL duty%0d_duty: got %0d expected %0d", r, o.duty, e.duty); else n_pass++;
        end
      end
      n_checks++; if (obs_q.size() != 0) $display("FAIL duty%0d_extra: %0d unexpected valid pulses, expected 0", r, obs_q.size()); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL duty%0d_overrun: got %b expected 0", r, overrun); else n_pass++;
    end
  endtask

  task automatic test_stuck();
    int t0;
    int k;
    pwm_in = 1'b0;
    rst_n  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    t0 = cyc;
    for (k = 0; k < CNT_MAX + 100 && stuck !== 1'b1; k++) tick(1);
    n_checks++; if (stuck !== 1'b1) $display("FAIL stuck_low_set: got %b expected 1", stuck); else n_pass++;
    n_checks++;
    if (cyc - t0 < CNT_MAX - 2 || cyc - t0 > CNT_MAX + 4)
      $display("FAIL stuck_low_time: after %0d cycles expected about %0d", cyc - t0, CNT_MAX);
    else n_pass++;
    n_checks++; if (duty !== DUTY_BITS'(MAXD)) $display("FAIL stuck_low_duty: got %0d expected %0d", duty, MAXD); else n_pass++;
    n_checks++; if (period !== '0) $display("FAIL stuck_low_period: got %0d expected 0", period); else n_pass++;
    n_checks++; if (on_time !== '0) $display("FAIL stuck_low_on_time: got %0d expected 0", on_time); else n_pass++;
    tick(20);
    n_checks++; if (obs_q.size() != 1) $display("FAIL stuck_low_pulses: got %0d valid pulses expected 1", obs_q.size()); else n_pass++;
    pwm_in = 1'b1;
    tick(DET + 3);
    n_checks++; if (stuck !== 1'b0) $display("FAIL stuck_fall_clear: got %b expected 0", stuck); else n_pass++;
    n_checks++; if (duty !== DUTY_BITS'(MAXD)) $display("FAIL stuck_fall_hold: got %0d expected %0d", duty, MAXD); else n_pass++;
    obs_q.delete();
    for (k = 0; k < CNT_MAX + 100 && stuck !== 1'b1; k++) tick(1);
    n_checks++; if (stuck !== 1'b1) $display("FAIL stuck_high_set: got %b expected 1", stuck); else n_pass++;
    n_checks++; if (duty !== '0) $display("FAIL stuck_high_duty: got %0d expected 0", duty); else n_pass++;
    tick(20);
    n_checks++; if (obs_q.size() != 1) $display("FAIL stuck_high_pulses: got %0d valid pulses expected 1", obs_q.size()); else n_pass++;
    pwm_in = 1'b0;
    tick(DET + 3);
    n_checks++; if (stuck !== 1'b0) $display("FAIL stuck_rise_clear: got %b expected 0", stuck); else n_pass++;
  endtask

  task automatic test_overrun();
    meas_t e, o;
    do_reset();
    run_pwm(8, 8, 4, 0);
    for (int k = 0; k < LAT + 60 && obs_q.size() < exp_q.size(); k++) tick(1);
    tick(LAT + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        $display("FAIL ovr_valid: no valid pulse, expected at cycle %0d", e.cyc);
      end else begin
        n_pass++;
        o = obs_q.pop_front();
        n_checks++; if (o.cyc !== e.cyc) $display("FAIL ovr_latency: valid at cycle %0d expected %0d", o.cyc, e.cyc); else n_pass++;
        n_checks++; if (o.per !== e.per) $display("FAIL ovr_period: got %0d expected %0d", o.per, e.per); else n_pass++;
        n_checks++; if (o.on !== e.on) $display("FAIL ovr_on_time: got %0d expected %0d", o.on, e.on); else n_pass++;
        n_checks++; if (o.duty !== e.duty) $display("FAIL ovr_duty: got %0d expected %0d", o.duty, e.duty); else n_pass++;
      end
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL ovr_extra: %0d unexpected valid pulses, expected 0", obs_q.size()); else n_pass++;
    n_checks++; if (overrun !== exp_ovr) $display("FAIL ovr_flag: got %b expected %b", overrun, exp_ovr); else n_pass++;
    n_checks++; if (period !== CNT_W'(16)) $display("FAIL ovr_hold_period: got %0d expected 16", period); else n_pass++;
  endtask

  task automatic test_reset_mid();
    meas_t e, o;
    do_reset();
    run_pwm(512, 512, 1, 0);
    tick(LAT + 10);
    n_checks++; if (period !== CNT_W'(1024)) $display("FAIL mid_pre_period: got %0d expected 1024", period); else n_pass++;
    pwm_in = 1'b1;
    tick(512);
    pwm_in = 1'b0;
    tick(DET + 8);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (duty !== '0) $display("FAIL mid_async_duty: got %0d expected 0", duty); else n_pass++;
    n_checks++; if (period !== '0) $display("FAIL mid_async_period: got %0d expected 0", period); else n_pass++;
    n_checks++; if (on_time !== '0) $display("FAIL mid_async_on_time: got %0d expected 0", on_time); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    exp_ovr    = 1'b0;
    last_start = -1000000;
    tick(LAT + 20);
    n_checks++; if (obs_q.size() != 0) $display("FAIL mid_no_valid: got %0d valid pulses expected 0", obs_q.size()); else n_pass++;
    run_pwm(256, 768, 1, 0);
    for (int k = 0; k < LAT + 60 && obs_q.size() < exp_q.size(); k++) tick(1);
    tick(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        $display("FAIL mid_valid: no valid pulse, expected at cycle %0d", e.cyc);
      end else begin
        n_pass++;
        o = obs_q.pop_front();
        n_checks++; if (o.cyc !== e.cyc) $display("FAIL mid_latency: valid at cycle %0d expected %0d", o.cyc, e.cyc); else n_pass++;
        n_checks++; if (o.per !== e.per) $display("FAIL mid_period: got %0d expected %0d", o.per, e.per); else n_pass++;
        n_checks++; if (o.on !== e.on) $display("FAIL mid_on_time: got %0d expected %0d", o.on, e.on); else n_pass++;
        n_checks++; if (o.duty !== e.duty) $display("FAIL mid_duty: got %0d expected %0d", o.duty, e.duty); else n_pass++;
      end
    end
    n_checks++; if (overrun !== 1'b0) $display("FAIL mid_overrun: got %b expected 0", overrun); else n_pass++;
  endtask

  task automatic test_glitch();
    meas_t e, o;
    bit    bad;
    do_reset();
    run_pwm(512, 512, 3, 200);
`ifdef PWM_CAP_GLITCH_EN
    for (int k = 0; k < LAT + 60 && obs_q.size() < exp_q.size(); k++) tick(1);
    tick(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        $display("FAIL glitch_valid: no valid pulse, expected at cycle %0d", e.cyc);
      end else begin
        n_pass++;
        o = obs_q.pop_front();
        n_checks++; if (o.per !== e.per) $display("FAIL glitch_period: got %0d expected %0d", o.per, e.per); else n_pass++;
        n_checks++; if (o.on !== e.on) $display("FAIL glitch_on_time: got %0d expected %0d", o.on, e.on); else n_pass++;
        n_checks++; if (o.duty !== e.duty) $display("FAIL glitch_duty: got %0d expected %0d", o.duty, e.duty); else n_pass++;
      end
    end
    n_checks++; if (overrun !== 1'b0) $display("FAIL glitch_overrun: got %b expected 0", overrun); else n_pass++;
`else
    tick(LAT + 40);
    bad = (overrun === 1'b1);
    foreach (obs_q[i]) if (obs_q[i].per != 1024) bad = 1'b1;
    n_checks++; if (!bad) $display("FAIL glitch_unfiltered: spikes went unnoticed (got clean, expected disturbed)"); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_duty_patterns();
    test_stuck();
    test_overrun();
    test_reset_mid();
    test_glitch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_capture.md
Name: pwm_duty_capture

Overview:
- Receive side of the board's LED PWM drive: samples an active-low PWM waveform on one pin and measures its period and on-time in clk cycles.
- Converts the measurement to a DUTY_BITS-wide intensity code, the same scale the PWM generators drive.
- Used for loop-back self-test of the RGB PWM outputs and for reading an external PWM source into the fabric.

Parameters:
- CNT_W, 16: width of the period/on-time counters; saturation at 2^CNT_W-1 is the no-edge timeout.
- DUTY_BITS, 4: width of the duty code; full scale is MAXD = 2^DUTY_BITS-1.
- ACTIVE_LOW, 1: 1 means pin low = active (on); 0 means pin high = active.
- GLITCH_CYCLES, 4: stability requirement used only when PWM_CAP_GLITCH_EN is defined.

Ports:
- clk, input, 1: system clock (12 MHz on the board).
- rst_n, input, 1: asynchronous, active-low reset.
- pwm_in, input, 1: asynchronous PWM pin.
- duty, output, DUTY_BITS: last computed duty code.
- period, output, CNT_W: last measured period in cycles.
- on_time, output, CNT_W: last measured active time in cycles.
- valid, output, 1: one-cycle pulse when duty/period/on_time update.
- stuck, output, 1: high while the input shows no edge for 2^CNT_W-1 cycles.
- overrun, output, 1: sticky; set when a period completes while the divider is busy.

Behaviour:
- Reset (async assert, sync release): all outputs 0; synchroniser flops 0; FSM to IDLE; divider idle.
- Input path: 2-flop synchroniser, then act = sync XOR ACTIVE_LOW inverted appropriately, so act=1 means the pin is in its on level.
  - Rise = act 0->1, fall = act 1->0, each detected on the cycle after the 2nd sync flop changes.
- FSM states:
  - IDLE -> ON on the first rise; on_cnt=1, per_cnt=1.
  - ON: both counters +1 per cycle. On fall: latch on_cnt, go to OFF.
  - OFF: per_cnt +1 per cycle. On rise (closing edge):
    - latch period=per_cnt and on_time=latched on_cnt;
    - start the divider;
    - restart per_cnt=1, on_cnt=1;
    - go to ON.
  - STUCK: see timeout below.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Timeout: per_cnt reaching 2^CNT_W-1 in ON or OFF, or no edge for 2^CNT_W-1 cycles in IDLE, enters STUCK.
  - On entry: period=0; on_time=0; duty=MAXD if act=1 else 0; stuck=1; one valid pulse.
  - STUCK -> ON on the next rise, with stuck cleared that cycle.
  - A fall while in STUCK with act previously 1 goes to IDLE; duty is held and stuck is cleared.
- Duty arithmetic: duty = floor((on_time*MAXD + floor(period/2)) / period), i.e. round-half-up; result is clamped to MAXD.
  - Computed by a sequential restoring divider, 1 quotient bit per cycle, numerator width CNT_W+DUTY_BITS.
- Latency:
  - duty, period, on_time and valid all update together.
  - valid is asserted exactly CNT_W+DUTY_BITS+1 cycles after the closing-edge detect cycle (cycle 0).
  - Outputs hold between updates.
- Overrun: a closing edge while the divider is busy discards that measurement and sets overrun. Counters restart normally. overrun is cleared only by reset.
- Simultaneous timeout and edge in the same cycle: the edge wins.
- Reset mid-measurement or mid-division aborts it; no valid pulse is produced.

Optional Feature:
- PWM_CAP_GLITCH_EN defined:
  - After synchronisation, act changes only once the synced level has held GLITCH_CYCLES consecutive cycles.
  - Shorter pulses are ignored.
  - Edge detection is delayed by GLITCH_CYCLES, equally for rise and fall, so period and on_time are unaffected.
- PWM_CAP_GLITCH_EN undefined: no filter; act is the synchronised level directly.

Test Plan:
- Active-low PWM, period 8192, low 4096 cycles, 3 periods -> each valid gives period=8192, on_time=4096, duty=8 (7.5 rounds up); valid exactly 21 cycles after the closing-edge detect.
- Period 8192, on 512 (1/16) -> duty=1 (0.94 rounds up); on 8192-512 -> duty=14; overrun stays 0.
- Pin held low (active) 70000 cycles after reset -> stuck=1 and duty=15 at cycle 65535 of no edges, single valid pulse; pin held high -> duty=0, stuck=1; a later rise clears stuck.
- Period 16 cycles (shorter than the 21-cycle divider latency) -> overrun=1; period/on_time reflect only measurements whose division completed.
- rst_n pulsed low mid-division -> all outputs 0 immediately (asynchronous), no valid; the next full period measures correctly.
- With PWM_CAP_GLITCH_EN, GLITCH_CYCLES=4: 2-cycle spikes inside a 4096/8192 PWM -> still duty=8, period=8192; without the macro the same stimulus corrupts the measurement or sets overrun.
